// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch stage of the multicycle MIPS core.
// Holds the PC, issues one word read at a time to instruction memory,
// registers the returned word, and hands it to decode with valid/ready.
// Redirects from branch/jump resolution reload the PC and flush any
// in-flight fetch (its response is dropped when it arrives).
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   imem_req/imem_addr         fetch request and address (address == pc)
//   imem_ready                 memory accepts request (req & ready)
//   imem_rvalid/imem_rdata     returned instruction word
//   instr_valid/instr_ready    handoff to decode (valid & ready)
//   instr/instr_pc             fetched word and its address
//   opcode/funct               instr[31:26] / instr[5:0]
//   redirect_valid/_pc         load new PC (highest priority)
//   misalign_err               one-cycle pulse on a misaligned redirect target
//   fetch_count                completed handoffs
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_FULL  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic            mis_q, mis_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      req_q   <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      req_q   <= req_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state logic; a redirect overrides every other event this cycle
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    mis_d   = 1'b0;

    if (redirect_valid) begin
      pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
      mis_d   = |redirect_pc[1:0];
      valid_d = 1'b0;
      case (state_q)
        S_IDLE:  state_d = S_FETCH;
        // Old-address request accepted this cycle: its response must be dropped
        S_FETCH: begin
          if (imem_ready) begin
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end
        end
        // Response arriving now is the stale one; it consumes the drop
        S_WAIT: begin
          if (imem_rvalid) begin
            state_d = S_FETCH;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
        S_FULL:  state_d = S_FETCH;
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_FETCH;
        S_FETCH: begin
          if (imem_ready) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_FETCH;
            end else begin
              instr_d = imem_rdata;
              ipc_d   = pc_q;
              valid_d = 1'b1;
              pc_d    = pc_q + XLEN'(4);
              state_d = S_FULL;
            end
          end
        end
        S_FULL: begin
          if (instr_ready) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + XLEN'(1);
            state_d = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Request is asserted exactly while the registered state is FETCH
    req_d = (state_d == S_FETCH);
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign instr_valid  = valid_q;
  assign instr        = instr_q;
  assign instr_pc     = ipc_q;
  assign opcode       = instr_q[31:26];
  assign funct        = instr_q[5:0];
  assign misalign_err = mis_q;
  assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: directed vector table, hand-written redirect
// sequences and randomized traffic, all checked against a transaction-level
// model (outstanding request, pending instruction, expected next PC).
module tb_ifetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .funct          (funct),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Transaction-level model state
  bit          m_idle;   // first cycle out of reset, no request yet
  bit          m_out;    // one request outstanding
  bit          m_stale;  // outstanding response belongs to a flushed PC
  logic [31:0] m_oaddr;
  logic [31:0] m_pc;     // address of the next fetch
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  int unsigned m_cnt;
  bit          m_mis;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h0000_0020;
    if (a == 32'h0040_0004) return 32'h8C08_0004;
    return {a[15:0] ^ 16'hA5C3, a[31:16] + 16'h1357};
  endfunction

  function automatic bit model_req();
    return !m_out && !m_valid && !m_idle;
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_out = 1'b0; m_stale = 1'b0; m_oaddr = '0;
    m_pc = RST_PC; m_valid = 1'b0; m_instr = '0; m_ipc = '0;
    m_cnt = 0; m_mis = 1'b0;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check32("req", 32'(imem_req), 32'(model_req()));
    check32("addr", imem_addr, m_pc);
    check32("valid", 32'(instr_valid), 32'(m_valid));
    check32("count", fetch_count, 32'(m_cnt));
    check32("misalign", 32'(misalign_err), 32'(m_mis));
    if (m_valid) begin
      check32("instr", instr, m_instr);
      check32("instr_pc", instr_pc, m_ipc);
      check32("opcode", 32'(opcode), 32'(m_instr[31:26]));
      check32("funct", 32'(funct), 32'(m_instr[5:0]));
    end
  endtask

  // One clock: drive at negedge, advance model, sample at next negedge
  task automatic step(input bit rst, input bit rdy, input bit rv, input bit ird,
                      input bit rd, input logic [31:0] rpc);
    bit acc, rv_real;
    logic [31:0] old_pc;
    rst_n = rst; imem_ready = rdy; imem_rvalid = rv; instr_ready = ird;
    redirect_valid = rd; redirect_pc = rpc;
    imem_rdata = (rv && m_out) ? mem_word(m_oaddr) : $urandom();
    if (!rst) begin
      model_reset();
    end else begin
      acc = model_req() && rdy;
      rv_real = rv && m_out;
      old_pc = m_pc;
      m_idle = 1'b0;
      if (rd) begin
        m_pc = {rpc[31:2], 2'b00};
        m_mis = |rpc[1:0];
        m_valid = 1'b0;
        if (rv_real) m_out = 1'b0;
        else if (m_out) m_stale = 1'b1;
        if (acc) begin m_out = 1'b1; m_stale = 1'b1; m_oaddr = old_pc; end
      end else begin
        m_mis = 1'b0;
        if (rv_real) begin
          m_out = 1'b0;
          if (!m_stale) begin
            m_valid = 1'b1; m_instr = mem_word(m_oaddr);
            m_ipc = m_oaddr; m_pc = m_oaddr + 32'd4;
          end
          m_stale = 1'b0;
        end else if (m_valid && ird) begin
          m_valid = 1'b0; m_cnt++;
        end
        if (acc) begin m_out = 1'b1; m_stale = 1'b0; m_oaddr = m_pc; end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    bit rst, rdy, rv, ird, rd;
    logic [31:0] rpc;
    bit e_req;
    logic [31:0] e_addr;
    bit e_v, chk;
    logic [31:0] e_instr, e_ipc;
    int unsigned e_cnt;
    bit e_mis;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit rdy, bit rv, bit ird, bit rd, logic [31:0] rpc,
                              bit e_req, logic [31:0] e_addr, bit e_v, bit chk,
                              logic [31:0] e_instr, logic [31:0] e_ipc,
                              int unsigned e_cnt, bit e_mis);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.ird = ird; v.rd = rd; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.chk = chk;
    v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_cnt = e_cnt; v.e_mis = e_mis;
    return v;
  endfunction

  initial begin
    logic [31:0] rpc;
    rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    model_reset();

    // rst rdy rv ird rd rpc | req addr v chk instr ipc cnt mis
    tbl.push_back(mk(0,0,0,0,0,0,            0,32'h0040_0000,0,1,32'h0,32'h0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,            1,32'h0040_0000,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,            0,32'h0040_0000,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,1,1,0,0,            0,32'h0040_0004,1,1,32'h0000_0020,32'h0040_0000,0,0));
    tbl.push_back(mk(1,0,0,1,0,0,            1,32'h0040_0004,0,0,0,0,1,0));
    tbl.push_back(mk(1,1,0,0,0,0,            0,32'h0040_0004,0,0,0,0,1,0));
    tbl.push_back(mk(1,0,1,0,0,0,            0,32'h0040_0008,1,1,32'h8C08_0004,32'h0040_0004,1,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1,0,0,0,0,0,          0,32'h0040_0008,1,1,32'h8C08_0004,32'h0040_0004,1,0));
    tbl.push_back(mk(1,0,0,1,0,0,            1,32'h0040_0008,0,0,0,0,2,0));
    tbl.push_back(mk(1,0,0,0,1,32'h100,      1,32'h100,0,0,0,0,2,0));
    tbl.push_back(mk(1,1,0,0,0,0,            0,32'h100,0,0,0,0,2,0));
    tbl.push_back(mk(1,0,0,0,1,32'h200,      0,32'h200,0,0,0,0,2,0));
    tbl.push_back(mk(1,0,1,0,0,0,            1,32'h200,0,0,0,0,2,0));
    tbl.push_back(mk(1,1,0,0,0,0,            0,32'h200,0,0,0,0,2,0));
    tbl.push_back(mk(1,0,1,0,0,0,            0,32'h204,1,1,mem_word(32'h200),32'h200,2,0));
    tbl.push_back(mk(1,0,0,1,0,0,            1,32'h204,0,0,0,0,3,0));
    tbl.push_back(mk(1,1,0,0,1,32'h300,      0,32'h300,0,0,0,0,3,0));
    tbl.push_back(mk(1,0,1,0,0,0,            1,32'h300,0,0,0,0,3,0));
    tbl.push_back(mk(1,1,0,0,0,0,            0,32'h300,0,0,0,0,3,0));
    tbl.push_back(mk(1,0,1,1,0,0,            0,32'h304,1,1,mem_word(32'h300),32'h300,3,0));
    tbl.push_back(mk(1,0,0,1,1,32'h502,      1,32'h500,0,0,0,0,3,1));
    tbl.push_back(mk(1,0,0,0,0,0,            1,32'h500,0,0,0,0,3,0));
    tbl.push_back(mk(1,0,0,0,1,32'hFFFF_FFFC,1,32'hFFFF_FFFC,0,0,0,0,3,0));
    tbl.push_back(mk(1,1,0,0,0,0,            0,32'hFFFF_FFFC,0,0,0,0,3,0));
    tbl.push_back(mk(1,0,1,0,0,0,            0,32'h0,1,1,mem_word(32'hFFFF_FFFC),32'hFFFF_FFFC,3,0));
    tbl.push_back(mk(1,0,0,1,0,0,            1,32'h0,0,0,0,0,4,0));
    tbl.push_back(mk(1,1,0,0,0,0,            0,32'h0,0,0,0,0,4,0));
    tbl.push_back(mk(0,0,0,0,0,0,            0,32'h0040_0000,0,1,32'h0,32'h0,0,0));
    tbl.push_back(mk(1,0,1,0,0,0,            1,32'h0040_0000,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,            0,32'h0040_0000,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,1,1,0,0,            0,32'h0040_0004,1,1,32'h0000_0020,32'h0040_0000,0,0));
    tbl.push_back(mk(1,0,0,1,0,0,            1,32'h0040_0004,0,0,0,0,1,0));

    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].ird, tbl[i].rd, tbl[i].rpc);
      check32($sformatf("vec%0d_req", i), 32'(imem_req), 32'(tbl[i].e_req));
      check32($sformatf("vec%0d_addr", i), imem_addr, tbl[i].e_addr);
      check32($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(tbl[i].e_v));
      check32($sformatf("vec%0d_count", i), fetch_count, 32'(tbl[i].e_cnt));
      check32($sformatf("vec%0d_mis", i), 32'(misalign_err), 32'(tbl[i].e_mis));
      if (tbl[i].chk) begin
        check32($sformatf("vec%0d_instr", i), instr, tbl[i].e_instr);
        check32($sformatf("vec%0d_ipc", i), instr_pc, tbl[i].e_ipc);
        check32($sformatf("vec%0d_opcode", i), 32'(opcode), 32'(tbl[i].e_instr[31:26]));
        check32($sformatf("vec%0d_funct", i), 32'(funct), 32'(tbl[i].e_instr[5:0]));
      end
    end

    // Back-to-back redirects while waiting: last target wins, one response dropped
    step(1,1,0,0,0,0);
    step(1,0,0,0,1,32'h40);
    step(1,0,0,0,1,32'h83);
    check32("b2b_mis", 32'(misalign_err), 32'd1);
    step(1,0,1,0,0,0);
    check32("b2b_drop_valid", 32'(instr_valid), 32'd0);
    check32("b2b_addr", imem_addr, 32'h80);
    step(1,1,0,0,0,0);
    step(1,0,1,0,0,0);
    check32("b2b_ipc", instr_pc, 32'h80);
    check32("b2b_instr", instr, mem_word(32'h80));
    step(1,0,0,1,0,0);

    // Back-to-back redirects in FETCH without acceptance
    step(1,0,0,0,1,32'h10);
    step(1,0,0,0,1,32'h14);
    check32("fetch_b2b_addr", imem_addr, 32'h14);
    check32("fetch_b2b_req", 32'(imem_req), 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      bit rst, rdy, rv, ird, rd;
      rst = ($urandom_range(0, 299) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      rv  = m_out ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      ird = ($urandom_range(0, 2) != 0);
      rd  = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 2))
        0:       rpc = $urandom();
        1:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: rpc = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 3));
      endcase
      step(rst, rdy, rv, ird, rd, rpc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
